gdp_controller: RTL and testbench



---
 rtl/gdp_controller.sv | 100 ++++++++++
 tb/tb_gdp_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/gdp_controller.sv
// gdp_controller: scores every senone as k - sum(omega*(x-mean)^2) for each new feature vector.
module gdp_controller #(
    parameter int NUM_DIMS    = 26,
    parameter int NUM_SENONES = 256,
    parameter int FRAC_BITS   = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_vector_available,
    input  logic [NUM_DIMS-1:0][15:0]         x,
    input  logic signed [15:0]                mean,
    input  logic signed [15:0]                omega,
    input  logic signed [15:0]                k,
    input  logic                              new_stats_available,
    output logic                              get_new_stats,
    output logic [7:0]                        senone_index,
    output logic signed [15:0]                senone_score,
    output logic                              score_ready,
    output logic                              gdp_idle
);
    localparam int DW = $clog2(NUM_DIMS);

    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

    state_t                      state, state_n;
    logic [NUM_DIMS-1:0][15:0]   x_q;
    logic [DW-1:0]               dim;
    logic signed [39:0]          acc;
    logic signed [15:0]          k_q, score_q, sat;
    logic signed [16:0]          diff;
    logic signed [33:0]          sq_full;
    logic signed [25:0]          sq;
    logic signed [41:0]          term_full;
    logic signed [39:0]          term;
    logic signed [40:0]          res;
    logic                        hs, last_dim, last_sen;

    assign hs       = state == FETCH && new_stats_available;
    assign last_dim = dim == DW'(NUM_DIMS - 1);
    assign last_sen = senone_index == 8'(NUM_SENONES - 1);

    // Squared difference is non-negative and below 2^24 after rescaling, so 26 bits suffice.
    assign diff      = 17'($signed(x_q[dim])) - 17'(mean);
    assign sq_full   = diff * diff;
    assign sq        = 26'(sq_full >>> FRAC_BITS);
    assign term_full = sq * omega;
    assign term      = 40'(term_full >>> FRAC_BITS);

    assign res = 41'(k_q) - 41'(acc);
    assign sat = res > 41'sd32767 ? 16'sh7fff : res < -41'sd32768 ? 16'sh8000 : res[15:0];

    assign get_new_stats = state == FETCH;
    assign gdp_idle      = state == IDLE;
    assign score_ready   = state == EMIT;
    assign senone_score  = score_ready ? sat : score_q;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = new_vector_available ? FETCH : IDLE;
            FETCH:   state_n = hs && last_dim ? EMIT : FETCH;
            EMIT:    state_n = last_sen ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x_q          <= '0;
            dim          <= '0;
            acc          <= '0;
            k_q          <= '0;
            score_q      <= '0;
            senone_index <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && new_vector_available) begin
                x_q          <= x;
                senone_index <= '0;
                dim          <= '0;
                acc          <= '0;
            end
            if (hs) begin
                acc <= acc + term;
                dim <= dim + 1'b1;
                if (dim == '0)
                    k_q <= k;
            end
            if (state == EMIT) begin
                score_q <= sat;
                if (!last_sen) begin
                    senone_index <= senone_index + 1'b1;
                    dim          <= '0;
                    acc          <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gdp_controller.sv
// tb_gdp_controller: table-driven passes plus a randomized pass against an arithmetic reference model.
module tb_gdp_controller;
    localparam int ND = 26;
    localparam int NS = 256;

    logic                    clk = 0, reset = 1, nva = 0, nsa = 0;
    logic [ND-1:0][15:0]     x = '0;
    logic signed [15:0]      mean = 0, omega = 0, k = 0;
    logic                    get_new_stats, score_ready, gdp_idle;
    logic [7:0]              senone_index;
    logic signed [15:0]      senone_score;

    int checks = 0, fails = 0;

    typedef struct {
        logic [15:0] xv, mv, ov, kv, ev;
        bit          tog;
    } vec_t;
    vec_t tbl[4];

    gdp_controller dut (
        .clk(clk), .reset(reset), .new_vector_available(nva), .x(x),
        .mean(mean), .omega(omega), .k(k), .new_stats_available(nsa),
        .get_new_stats(get_new_stats), .senone_index(senone_index),
        .senone_score(senone_score), .score_ready(score_ready), .gdp_idle(gdp_idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sat16(input longint v);
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
    endfunction

    function automatic longint term_of(input logic signed [15:0] xi, m, o);
        longint d  = longint'(xi) - longint'(m);
        longint sq = (d * d) >>> 8;
        return (sq * longint'(o)) >>> 8;
    endfunction

    task automatic run_pass(input vec_t v, input bit rnd);
        logic signed [15:0] xs[ND];
        logic signed [15:0] kl = 0;
        logic [15:0]        last_exp = 0;
        longint             acc = 0;
        int                 dim = 0, sen = 0, last = 0;
        bit                 emit = 0, done = 0, cur;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            xs[i] = rnd ? 16'($urandom_range(0, 511)) - 16'd256 : v.xv;
            x[i]  = xs[i];
        end
        nva = 1;
        nsa = 0;
        @(negedge clk);
        for (int c = 0; c < 20000 && !done; c++) begin
            nva = 0;
            if (rnd)
                for (int i = 0; i < ND; i++) x[i] = 16'($urandom);
            cur = emit;
            check("get_new_stats", get_new_stats, !cur);
            check("score_ready", score_ready, cur);
            if (cur) begin
                last_exp = rnd ? sat16(longint'(kl) - acc) : v.ev;
                check("senone_index", senone_index, 16'(sen));
                check("senone_score", senone_score, last_exp);
                if (!v.tog && !rnd)
                    check("spacing", 16'(c - last), sen == 0 ? 16'd26 : 16'd27);
                last = c;
                sen++;
                emit = 0;
                acc  = 0;
                dim  = 0;
                done = sen == NS;
            end
            if (!done) begin
                nsa   = rnd ? $urandom_range(0, 3) != 0 : v.tog ? c % 2 == 0 : 1'b1;
                mean  = rnd ? 16'($urandom_range(0, 511)) - 16'd256 : v.mv;
                omega = rnd ? 16'($urandom_range(0, 319)) - 16'd64 : v.ov;
                k     = rnd ? 16'($urandom_range(0, 32767)) - 16'd16384 : v.kv;
                if (!cur && nsa) begin
                    if (dim == 0) kl = k;
                    acc += term_of(xs[dim], mean, omega);
                    dim++;
                    emit = dim == ND;
                end
            end
            @(negedge clk);
        end
        check("pass_complete", 16'(done), 16'd1);
        nsa = 0;
        check("idle_after", gdp_idle, 1'b1);
        check("gns_after", get_new_stats, 1'b0);
        check("index_hold", senone_index, 16'(NS - 1));
        check("score_hold", senone_score, last_exp);
    endtask

    initial begin
        tbl[0] = '{16'h0000, 16'h0000, 16'h0100, 16'h1234, 16'h1234, 1'b0};
        tbl[1] = '{16'h0100, 16'h0000, 16'h0100, 16'h2000, 16'h0600, 1'b0};
        tbl[2] = '{16'h0100, 16'h0000, 16'h0100, 16'h2000, 16'h0600, 1'b1};
        tbl[3] = '{16'h7fff, 16'h8000, 16'h7fff, 16'h8000, 16'h8000, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_idle", gdp_idle, 1'b1);
        check("rst_gns", get_new_stats, 1'b0);
        check("rst_ready", score_ready, 1'b0);
        check("rst_score", senone_score, 16'h0000);
        check("rst_index", senone_index, 16'h0000);
        reset = 0;

        foreach (tbl[i]) run_pass(tbl[i], 1'b0);
        run_pass(tbl[0], 1'b1);

        // Abort mid-FETCH of senone 5, then a fresh pass must start clean.
        @(negedge clk);
        for (int i = 0; i < ND; i++) x[i] = 16'h0100;
        mean  = 16'h0300;
        omega = 16'h0100;
        k     = 16'h0000;
        nsa   = 1;
        nva   = 1;
        @(negedge clk);
        nva = 0;
        for (int c = 0; c < 1000 && !(senone_index == 8'd5 && get_new_stats); c++)
            @(negedge clk);
        check("reach_senone5", senone_index, 16'd5);
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("abort_idle", gdp_idle, 1'b1);
        check("abort_gns", get_new_stats, 1'b0);
        check("abort_ready", score_ready, 1'b0);
        check("abort_index", senone_index, 16'h0000);
        reset = 0;
        run_pass(tbl[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
